// File: rtl/bcd_display_counter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_display_counter
// Purpose : N-digit synchronous BCD up/down counter with multiplexed,
//           active-low 7-segment scan driver and leading-zero blanking.
// Revision: 1.0  initial release
// ============================================================================
module bcd_display_counter #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 100_000_000,
  parameter int REFRESH_DIV = 100_000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    count,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              out
);

  localparam int TW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST    = SW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_cnt;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] stepped;
  logic [4*NUM_DIGITS-1:0] loaded;
  logic                    step_carry;
  logic [RW-1:0]           refresh_cnt;
  logic [SW-1:0]           scan_idx;
  logic                    refresh_last;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [NUM_DIGITS-1:0]   anode_next;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [7:0]              out_next;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  assign tick         = (tick_cnt == TICK_LAST);
  assign refresh_last = (refresh_cnt == REFRESH_LAST);

  // A load restarts the tick period so the first step lands a full period later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              tick_cnt <= '0;
    else if (load || tick)  tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + TW'(1);
  end

  // Ripple carry/borrow resolved within one cycle; final carry marks a wrap.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    carry   = 1'b1;
    stepped = value;
    loaded  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = value[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d == 4'd9) stepped[4*i +: 4] = 4'd0;
          else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) stepped[4*i +: 4] = 4'd9;
          else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
      loaded[4*i +: 4] = (data_in[4*i +: 4] > 4'd9) ? 4'd9 : data_in[4*i +: 4];
    end
    step_carry = carry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        value <= loaded;
      end else if (tick && count) begin
        value <= stepped;
        wrap  <= step_carry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_last) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == SCAN_LAST) ? '0 : scan_idx + SW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // upper_zero[i] is set when digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic zeros;
    zeros      = 1'b1;
    upper_zero = '0;
    anode_next = '1;
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros         = zeros && (value[4*i +: 4] == 4'd0);
      upper_zero[i] = zeros;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (SW'(i) == scan_idx) begin
        anode_next[i] = 1'b0;
        cur_digit     = value[4*i +: 4];
        cur_blank     = BLANK_LZ && (i > 0) && upper_zero[i];
      end
    end
    out_next = cur_blank ? 8'hFF : seg_code(cur_digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode <= '1;
      out   <= 8'hFF;
    end else begin
      anode <= anode_next;
      out   <= out_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_display_counter
// Purpose : Directed plus random bench against a decimal-integer reference.
// Revision: 1.0  initial release
// ============================================================================
module tb_bcd_display_counter;

  localparam int ND  = 4;
  localparam int TD  = 4;
  localparam int RD  = 2;
  localparam int MOD = 10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        count;
  logic        up;
  logic        load;
  logic [15:0] data_in;
  logic [15:0] value;
  logic        wrap;
  logic [3:0]  anode;
  logic [7:0]  out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: count kept as a plain decimal integer.
  int         m_val, m_ph, m_scan, m_rph;
  logic       m_wrap;
  logic [3:0] m_anode;
  logic [7:0] m_out;

  bcd_display_counter #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .REFRESH_DIV(RD),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .count  (count),
    .up     (up),
    .load   (load),
    .data_in(data_in),
    .value  (value),
    .wrap   (wrap),
    .anode  (anode),
    .out    (out)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int k);
    int r = 1;
    for (int j = 0; j < k; j++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int clamp_dec(input logic [15:0] d);
    int r = 0;
    int nib;
    for (int i = 0; i < ND; i++) begin
      nib = int'(d[4*i +: 4]);
      if (nib > 9) nib = 9;
      r = r + nib * pow10(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input int dgt);
    case (dgt)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/value"}, 32'(value), 32'(to_bcd(m_val)));
    chk({tag, "/wrap"},  32'(wrap),  32'(m_wrap));
    chk({tag, "/anode"}, 32'(anode), 32'(m_anode));
    chk({tag, "/out"},   32'(out),   32'(m_out));
  endtask

  task automatic model_reset();
    m_val = 0; m_ph = 0; m_scan = 0; m_rph = 0;
    m_wrap = 1'b0; m_anode = 4'hF; m_out = 8'hFF;
  endtask

  // Drive inputs, advance one clock, update the reference, then compare.
  task automatic cycle(input string tag, input logic ld, input logic cnt,
                       input logic u, input logic [15:0] d);
    logic tick;
    load = ld; count = cnt; up = u; data_in = d;
    @(posedge clk);
    m_anode = ~(4'(1) << m_scan);
    if (m_scan > 0 && m_val < pow10(m_scan)) m_out = 8'hFF;
    else m_out = seg_of((m_val / pow10(m_scan)) % 10);
    if (m_rph == RD - 1) begin
      m_rph  = 0;
      m_scan = (m_scan + 1) % ND;
    end else begin
      m_rph++;
    end
    tick   = (m_ph == TD - 1);
    m_wrap = 1'b0;
    if (ld) begin
      m_val = clamp_dec(d);
      m_ph  = 0;
    end else begin
      if (tick && cnt) begin
        if (u) begin
          m_wrap = (m_val == MOD - 1);
          m_val  = (m_val + 1) % MOD;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MOD - 1) % MOD;
        end
      end
      m_ph = tick ? 0 : m_ph + 1;
    end
    #1;
    check_all(tag);
  endtask

  // Reset is asserted between edges and must take effect without a clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; count = 1'b0; up = 1'b1; load = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) cycle("first_step", 1'b0, 1'b1, 1'b1, 16'h0);
    chk("first_step_val", 32'(value), 32'h0001);
    repeat (2) cycle("pre_rst", 1'b0, 1'b1, 1'b1, 16'h0);
    do_reset("mid_rst");
    for (int k = 0; k < 3; k++) cycle("post_rst", 1'b0, 1'b1, 1'b1, 16'h0);
    chk("post_rst_hold", 32'(value), 32'h0000);
    cycle("post_rst", 1'b0, 1'b1, 1'b1, 16'h0);
    chk("post_rst_step", 32'(value), 32'h0001);

    cycle("ld0923", 1'b1, 1'b1, 1'b1, 16'h0923);
    chk("ld0923_val", 32'(value), 32'h0923);
    for (int k = 0; k < 4; k++) cycle("inc", 1'b0, 1'b1, 1'b1, 16'h0);
    chk("inc_val", 32'(value), 32'h0924);

    cycle("ld9999", 1'b1, 1'b0, 1'b1, 16'h9999);
    for (int k = 0; k < 4; k++) cycle("wrap_up", 1'b0, 1'b1, 1'b1, 16'h0);
    chk("wrap_up_val", 32'(value), 32'h0000);
    chk("wrap_up_pulse", 32'(wrap), 32'h1);
    cycle("wrap_up_end", 1'b0, 1'b0, 1'b1, 16'h0);
    chk("wrap_up_one", 32'(wrap), 32'h0);

    cycle("ld0000", 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 4; k++) cycle("wrap_dn", 1'b0, 1'b1, 1'b0, 16'h0);
    chk("wrap_dn_val", 32'(value), 32'h9999);
    chk("wrap_dn_pulse", 32'(wrap), 32'h1);

    cycle("ld1000", 1'b1, 1'b0, 1'b0, 16'h1000);
    for (int k = 0; k < 4; k++) cycle("borrow", 1'b0, 1'b1, 1'b0, 16'h0);
    chk("borrow_val", 32'(value), 32'h0999);

    cycle("clamp", 1'b1, 1'b0, 1'b1, 16'h0F0A);
    chk("clamp_val", 32'(value), 32'h0909);

    cycle("ld0005", 1'b1, 1'b0, 1'b1, 16'h0005);
    for (int k = 0; k < 3; k++) cycle("pre_tick", 1'b0, 1'b0, 1'b1, 16'h0);
    cycle("ld_on_tick", 1'b1, 1'b1, 1'b1, 16'h0300);
    chk("ld_on_tick_val", 32'(value), 32'h0300);
    chk("ld_on_tick_wrap", 32'(wrap), 32'h0);

    cycle("ld0042", 1'b1, 1'b0, 1'b1, 16'h0042);
    for (int k = 0; k < 10; k++) cycle("scan", 1'b0, 1'b0, 1'b1, 16'h0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
      cycle("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
